// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter
// Description : Two-port round-robin arbiter in front of a single-port data
//               memory. One transaction in flight: IDLE -> ACCESS -> DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_access = 2'd1;
    localparam logic [1:0] c_done   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_gnt;        // 1 = port 1 owns the current transaction
    logic              r_last_grant; // 1 = port 1 was granted last
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              w_any_req;
    logic              w_pick_p1;

    assign w_any_req = p0_req | p1_req;
    // Port 1 wins when alone, or on a tie when port 0 was granted last.
    assign w_pick_p1 = p1_req & (~p0_req | ~r_last_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:   if (w_any_req) w_next_state = c_access;
            c_access: w_next_state = c_done;
            c_done:   w_next_state = c_idle;
            default:  w_next_state = c_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt        <= 1'b0;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
        end else begin
            if (r_state == c_idle && w_any_req) begin
                r_gnt        <= w_pick_p1;
                r_last_grant <= w_pick_p1;
                r_we         <= w_pick_p1 ? p1_we    : p0_we;
                r_addr       <= w_pick_p1 ? p1_addr  : p0_addr;
                r_wdata      <= w_pick_p1 ? p1_wdata : p0_wdata;
            end
            // Writes leave the previously captured read data in place.
            if (r_state == c_access && !r_we) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        mem_we = 1'b0;
        p0_ack = 1'b0;
        p1_ack = 1'b0;
        case (r_state)
            c_access: mem_we = r_we;
            c_done: begin
                p0_ack = ~r_gnt;
                p1_ack = r_gnt;
            end
            default: ;
        endcase
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign p0_rdata  = r_rdata;
    assign p1_rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_arbiter
// Description : Self-checking bench for data_mem_arbiter against a
//               transaction-level round-robin model and a reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              p0_req, p0_we, p1_req, p1_we;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [DATA_W-1:0] p0_wdata, p1_wdata;
    logic              p0_ack, p1_ack;
    logic [DATA_W-1:0] p0_rdata, p1_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] dev_mem [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic              ref_last;
    logic [DATA_W-1:0] ref_rdata;

    int tests;
    int fails;

    data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_ack    (p0_ack),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_ack    (p1_ack),
        .p1_rdata  (p1_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = dev_mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) dev_mem[mem_addr] <= mem_wdata;
    end

    task automatic new_txn(input int port);
        if (port == 0) begin
            p0_req   = 1'b1;
            p0_we    = 1'($urandom_range(0, 1));
            p0_addr  = ADDR_W'($urandom_range(0, 31));
            p0_wdata = $urandom;
        end else begin
            p1_req   = 1'b1;
            p1_we    = 1'($urandom_range(0, 1));
            p1_addr  = ADDR_W'($urandom_range(0, 31));
            p1_wdata = $urandom;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (mem_we !== 1'b0 || p0_ack !== 1'b0 || p1_ack !== 1'b0) begin
            fails++;
            $display("FAIL reset_strobes: mem_we=%b p0_ack=%b p1_ack=%b expected 0 0 0", mem_we, p0_ack, p1_ack);
        end
        tests++;
        if (mem_addr !== '0 || mem_wdata !== '0 || p0_rdata !== '0) begin
            fails++;
            $display("FAIL reset_regs: mem_addr=%h mem_wdata=%h rdata=%h expected 0", mem_addr, mem_wdata, p0_rdata);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ref_last  = 1'b1;
        ref_rdata = '0;
    endtask

    task automatic test_tie_after_reset;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 14'd0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 14'd6;
        @(posedge clk); #1;
        tests++;
        if (mem_addr !== 14'd0 || mem_we !== 1'b0) begin
            fails++;
            $display("FAIL tie_first_access: mem_addr=%0d mem_we=%b expected 0 0", mem_addr, mem_we);
        end
        @(posedge clk); #1;
        tests++;
        if (p0_ack !== 1'b1 || p1_ack !== 1'b0 || p0_rdata !== ref_mem[0]) begin
            fails++;
            $display("FAIL tie_p0_done: p0_ack=%b p1_ack=%b rdata=%h expected 1 0 %h", p0_ack, p1_ack, p0_rdata, ref_mem[0]);
        end
        @(posedge clk); #1;
        p0_req = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (mem_addr !== 14'd6 || p0_ack !== 1'b0 || p1_ack !== 1'b0) begin
            fails++;
            $display("FAIL tie_second_access: mem_addr=%0d acks=%b%b expected 6 00", mem_addr, p0_ack, p1_ack);
        end
        @(posedge clk); #1;
        tests++;
        if (p1_ack !== 1'b1 || p0_ack !== 1'b0 || p1_rdata !== ref_mem[6]) begin
            fails++;
            $display("FAIL tie_p1_done: p1_ack=%b p0_ack=%b rdata=%h expected 1 0 %h", p1_ack, p0_ack, p1_rdata, ref_mem[6]);
        end
        ref_last  = 1'b1;
        ref_rdata = ref_mem[6];
        @(posedge clk); #1;
        p1_req = 1'b0;
    endtask

    task automatic test_write_read;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 14'd5; p0_wdata = 32'h12345678;
        @(posedge clk); #1;
        tests++;
        if (mem_we !== 1'b1 || mem_addr !== 14'd5 || mem_wdata !== 32'h12345678) begin
            fails++;
            $display("FAIL write_access: we=%b addr=%0d wdata=%h expected 1 5 12345678", mem_we, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        tests++;
        if (mem_we !== 1'b0 || p0_ack !== 1'b1 || p1_ack !== 1'b0 || p0_rdata !== ref_rdata) begin
            fails++;
            $display("FAIL write_done: we=%b p0_ack=%b p1_ack=%b rdata=%h expected 0 1 0 %h", mem_we, p0_ack, p1_ack, p0_rdata, ref_rdata);
        end
        @(posedge clk); #1;
        tests++;
        if (dev_mem[5] !== 32'h12345678 || p0_ack !== 1'b0) begin
            fails++;
            $display("FAIL write_commit: mem[5]=%h ack=%b expected 12345678 0", dev_mem[5], p0_ack);
        end
        ref_mem[5] = 32'h12345678;
        ref_last   = 1'b0;
        p0_we = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (mem_we !== 1'b0 || mem_addr !== 14'd5) begin
            fails++;
            $display("FAIL read_access: we=%b addr=%0d expected 0 5", mem_we, mem_addr);
        end
        @(posedge clk); #1;
        tests++;
        if (p0_ack !== 1'b1 || p0_rdata !== 32'h12345678 || mem_we !== 1'b0) begin
            fails++;
            $display("FAIL read_done: ack=%b rdata=%h we=%b expected 1 12345678 0", p0_ack, p0_rdata, mem_we);
        end
        ref_rdata = 32'h12345678;
        @(posedge clk); #1;
        p0_req = 1'b0;
    endtask

    // Transaction-level traffic: when keep_both is set every port always has
    // a request pending, which forces strict alternation.
    task automatic test_traffic(input int n, input bit keep_both);
        logic              exp_p1, exp_we;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_wdata;
        if (keep_both) begin
            new_txn(0);
            new_txn(1);
        end
        for (int t = 0; t < n; t++) begin
            if (!p0_req && !p1_req) begin
                @(posedge clk); #1;
                tests++;
                if (p0_ack !== 1'b0 || p1_ack !== 1'b0 || mem_we !== 1'b0) begin
                    fails++;
                    $display("FAIL idle_quiet: acks=%b%b we=%b expected 00 0", p0_ack, p1_ack, mem_we);
                end
                if ($urandom_range(0, 1) == 1) new_txn(0);
                if ($urandom_range(0, 1) == 1) new_txn(1);
                continue;
            end
            exp_p1    = (p0_req && p1_req) ? ~ref_last : p1_req;
            exp_we    = exp_p1 ? p1_we    : p0_we;
            exp_addr  = exp_p1 ? p1_addr  : p0_addr;
            exp_wdata = exp_p1 ? p1_wdata : p0_wdata;
            @(posedge clk); #1;
            tests++;
            if (mem_we !== exp_we || mem_addr !== exp_addr || (exp_we && mem_wdata !== exp_wdata)
                || p0_ack !== 1'b0 || p1_ack !== 1'b0) begin
                fails++;
                $display("FAIL traffic_access t=%0d: we=%b addr=%0d wdata=%h acks=%b%b expected %b %0d %h 00",
                         t, mem_we, mem_addr, mem_wdata, p0_ack, p1_ack, exp_we, exp_addr, exp_wdata);
            end
            if (exp_we) ref_mem[exp_addr] = exp_wdata;
            else        ref_rdata = ref_mem[exp_addr];
            ref_last = exp_p1;
            @(posedge clk); #1;
            tests++;
            if (p0_ack !== !exp_p1 || p1_ack !== exp_p1 || mem_we !== 1'b0 || mem_addr !== exp_addr
                || (exp_p1 ? p1_rdata : p0_rdata) !== ref_rdata) begin
                fails++;
                $display("FAIL traffic_done t=%0d: acks=%b%b we=%b addr=%0d rdata=%h expected %b%b 0 %0d %h",
                         t, p0_ack, p1_ack, mem_we, mem_addr, exp_p1 ? p1_rdata : p0_rdata,
                         !exp_p1, exp_p1, exp_addr, ref_rdata);
            end
            @(posedge clk); #1;
            tests++;
            if (p0_ack !== 1'b0 || p1_ack !== 1'b0 || mem_we !== 1'b0 || dev_mem[exp_addr] !== ref_mem[exp_addr]) begin
                fails++;
                $display("FAIL traffic_idle t=%0d: acks=%b%b we=%b mem=%h expected 00 0 %h",
                         t, p0_ack, p1_ack, mem_we, dev_mem[exp_addr], ref_mem[exp_addr]);
            end
            if (keep_both || $urandom_range(0, 2) != 0) new_txn(exp_p1 ? 1 : 0);
            else if (exp_p1) p1_req = 1'b0;
            else             p0_req = 1'b0;
            if (!keep_both && !(exp_p1 ? p0_req : p1_req) && $urandom_range(0, 1) == 1)
                new_txn(exp_p1 ? 0 : 1);
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    task automatic test_reset_during_access;
        logic [DATA_W-1:0] old;
        old    = dev_mem[10];
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 14'd10; p1_wdata = ~old;
        @(posedge clk); #1;
        tests++;
        if (mem_we !== 1'b1 || mem_addr !== 14'd10) begin
            fails++;
            $display("FAIL abort_access: we=%b addr=%0d expected 1 10", mem_we, mem_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (mem_we !== 1'b0 || p1_ack !== 1'b0) begin
            fails++;
            $display("FAIL abort_async: we=%b p1_ack=%b expected 0 0", mem_we, p1_ack);
        end
        p1_req = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (dev_mem[10] !== old || p1_ack !== 1'b0 || mem_addr !== '0) begin
            fails++;
            $display("FAIL abort_nowrite: mem[10]=%h ack=%b addr=%0d expected %h 0 0", dev_mem[10], p1_ack, mem_addr, old);
        end
        #3 rst_n = 1'b1;
        ref_last  = 1'b1;
        ref_rdata = '0;
        repeat (3) begin
            @(posedge clk); #1;
            tests++;
            if (p0_ack !== 1'b0 || p1_ack !== 1'b0 || mem_we !== 1'b0) begin
                fails++;
                $display("FAIL abort_noack: acks=%b%b we=%b expected 00 0", p0_ack, p1_ack, mem_we);
            end
        end
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 14'd10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if (p1_ack !== 1'b1 || p1_rdata !== old) begin
            fails++;
            $display("FAIL abort_recover: p1_ack=%b rdata=%h expected 1 %h", p1_ack, p1_rdata, old);
        end
        @(posedge clk); #1;
        p1_req = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        ref_last  = 1'b1;
        ref_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            dev_mem[i] = 32'hA5000000 ^ (i * 32'h00010203);
            ref_mem[i] = 32'hA5000000 ^ (i * 32'h00010203);
        end
        #2;
        test_reset();
        test_tie_after_reset();
        test_write_read();
        test_traffic(6, 1'b1);
        test_traffic(200, 1'b0);
        test_reset_during_access();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 14, word-address width of the data memory.
REQ-002 Parameter: DATA_W, default 32, data word width.
REQ-003 clk  input  1  single system clock; all state updates on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 p0_req  input  1  port 0 (CPU load/store) access request.
REQ-006 p0_we  input  1  port 0 write enable (1 = write, 0 = read).
REQ-007 p0_addr  input  ADDR_W  port 0 word address.
REQ-008 p0_wdata  input  DATA_W  port 0 write data.
REQ-009 p0_ack  output  1  port 0 transaction complete, one-cycle pulse.
REQ-010 p0_rdata  output  DATA_W  port 0 read data, valid while p0_ack=1.
REQ-011 p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata have the same directions, widths and meanings as the port 0 signals, for port 1 (DMA/debug).
REQ-012 mem_addr  output  ADDR_W  data memory address.
REQ-013 mem_we  output  1  data memory write strobe (memory MW).
REQ-014 mem_wdata  output  DATA_W  data memory write data.
REQ-015 mem_rdata  input  DATA_W  data memory combinational read data.

Function
REQ-016 FSM states: IDLE, ACCESS, DONE; at most one transaction in flight.
REQ-017 IDLE: if no req is asserted, stay in IDLE; otherwise latch the winner's id, we, addr and wdata into registers and go to ACCESS.
REQ-018 Arbitration: a single requester wins; on simultaneous requests, the port not granted last wins (round-robin).
REQ-019 last_grant updates only on the IDLE->ACCESS transition.
REQ-020 ACCESS lasts exactly one cycle: mem_addr = latched addr, mem_wdata = latched wdata, mem_we = latched we.
REQ-021 A write commits at the posedge ending ACCESS.
REQ-022 A read captures mem_rdata into the rdata register at the posedge ending ACCESS; ACCESS goes to DONE.
REQ-023 DONE lasts one cycle: the granted port's ack = 1, and its rdata = the captured value (the last captured value for writes); DONE goes to IDLE.
REQ-024 Latency: req sampled in IDLE at edge N; ack high in cycle N+2. Each transaction occupies 3 cycles.
REQ-025 mem_we SHALL be 0 in every state except ACCESS; mem_addr and mem_wdata hold their latched values outside ACCESS.
REQ-026 The non-granted port's ack stays 0. Its rdata output is the shared rdata register and is not valid.
REQ-027 Requester protocol: hold req, we, addr and wdata stable until ack. In the cycle after ack, either drop req or present the next transaction.
REQ-028 A req that stays high after ack is treated as a new request in IDLE.
REQ-029 Round-robin applies when both ports stay high, so ports alternate and neither starves.
REQ-030 A req asserted or deasserted while in ACCESS or DONE is ignored until IDLE.

Reset
REQ-031 When rst_n = 0: state = IDLE; mem_we = 0 immediately (asynchronous); p0_ack = p1_ack = 0.
REQ-032 Also on reset: last_grant = port 1 (so port 0 wins the first tie); rdata register, mem_addr and mem_wdata = 0.
REQ-033 Reset during ACCESS aborts the transaction: no write commits after rst_n falls, and no ack is issued.
REQ-034 After rst_n rises, operation resumes from IDLE at the first posedge.

Verification
REQ-035 p0 write addr 5 data 0x12345678 alone -> mem_we = 1 for exactly one cycle with mem_addr = 5; p0_ack pulses 2 cycles after sampling; memory[5] = 0x12345678.
REQ-036 p0 read addr 5 after REQ-035 -> p0_ack for one cycle with p0_rdata = 0x12345678; mem_we stays 0.
REQ-037 p0 and p1 both assert reads (addr 0 and addr 6) in the first IDLE after reset -> p0 is granted first; p1_ack follows 3 cycles after p0_ack; the acks never overlap.
REQ-038 Both reqs held high for 6 transactions -> grants alternate p0, p1, p0, p1, p0, p1 at a 3-cycle spacing.
REQ-039 Assert rst_n = 0 during the ACCESS of a p1 write to addr 10 -> mem_we drops to 0 at once; memory[10] is unchanged; p1_ack never pulses; the next transaction completes normally.
